mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the read-response watchdog limit in cycles, range 2..255.
REQ-002 SHALL have one clock and a synchronous, active-high reset; ports clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req_valid_in  input  1  core requests an access.
REQ-006 req_ready_out  output  1  unit can accept a request.
REQ-007 req_addr_in  input  32  byte address.
REQ-008 req_wdata_in  input  32  store data, right-aligned.
REQ-009 req_we_in  input  1  1 = store, 0 = load.
REQ-010 req_size_in  input  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-011 req_unsigned_in  input  1  zero-extend the load result.
REQ-012 resp_valid_out  output  1  one-cycle completion pulse.
REQ-013 resp_rdata_out  output  32  extended load data; 0 for stores and errors.
REQ-014 resp_err_out  output  1  error qualifier, valid with resp_valid_out.
REQ-015 ram_valid_out / ram_ready_in  out/in  1/1  RAM request handshake.
REQ-016 ram_addr_out  output  32  word index, {2'b00, addr[31:2]}.
REQ-017 ram_write_data_out  output  32  store data, unshifted; the RAM places the lanes.
REQ-018 ram_read_en_out / ram_write_en_out  output  1/1  access direction.
REQ-019 ram_write_byte_en_out  output  4  lane mask.
REQ-020 ram_rdata_valid_in / ram_read_data_in  input  1/32  read return.

Function
REQ-021 SHALL implement an FSM with states IDLE, REQ, WAIT_R and RESP.
REQ-022 IDLE: req_ready_out=1, and only in IDLE; a request is accepted when req_valid_in is high in IDLE; all request fields are registered on acceptance.
REQ-023 An accepted request with size 11, or misaligned (half with addr[0]=1, word with addr[1:0]!=0), SHALL go IDLE->RESP with resp_err_out=1 and no RAM access.
REQ-024 Otherwise the next state is REQ, where ram_valid_out=1; all ram_* request outputs SHALL stay stable until ram_valid_out && ram_ready_in.
REQ-025 The RAM lane mask SHALL be: byte -> 4'b0001<<addr[1:0]; half -> addr[1] ? 4'b1100 : 4'b0011; word -> 4'b1111; the mask is 0 for loads.
REQ-026 Store handshake SHALL go REQ->RESP: no read data is awaited, resp_err_out=0.
REQ-027 Load handshake SHALL go REQ->WAIT_R.
REQ-028 In WAIT_R, ram_valid_out=0; when ram_rdata_valid_in=1, capture ram_read_data_in and go to RESP.
REQ-029 Load result SHALL be the lane selected by addr[1:0] (byte) or addr[1] (half), shifted to bit 0, then sign-extended unless req_unsigned_in was set; word loads pass through unchanged.
REQ-030 RESP SHALL last exactly one cycle with resp_valid_out=1, then return to IDLE; there is no response backpressure.
REQ-031 Best-case latency, acceptance to resp_valid_out: store 2 cycles, load 3 cycles; error 1 cycle.
REQ-032 ram_rdata_valid_in SHALL be ignored outside WAIT_R.
REQ-033 req_valid_in SHALL be ignored outside IDLE.

Reset
REQ-034 rst SHALL force the state to IDLE within the same edge, including mid-transaction; any outstanding RAM access is abandoned and produces no response.
REQ-035 Reset values: req_ready_out=1 after reset; all other outputs, the watchdog counter and all captured data SHALL be 0.

Configuration
REQ-036 Macro MAU_TIMEOUT_EN defined: an 8-bit counter clears on entry to WAIT_R and increments each WAIT_R cycle; reaching TIMEOUT_CYCLES without ram_rdata_valid_in SHALL go to RESP with resp_err_out=1 and resp_rdata_out=0.
REQ-037 Macro undefined: no counter is built, and WAIT_R SHALL wait indefinitely.

Structure
REQ-038 A shared package mau_pkg SHALL hold the FSM state encoding, the size codes (SZ_BYTE, SZ_HALF, SZ_WORD) and the lane-mask constants.
REQ-039 Lane-mask generation and load extraction/extension SHALL live in a combinational sub-module mau_lane_align.

Verification
REQ-040 SB, addr 0x0000_0013, wdata 0x0000_00AB, ram_ready_in=1 -> ram_addr_out=0x4, mask 4'b1000, write data 0xAB, resp_valid_out 2 cycles after acceptance, err=0.
REQ-041 LH signed, addr 0x0000_0006, RAM returns 0x8001_1234 one cycle after handshake -> resp_rdata_out=0xFFFF_8001, 3-cycle latency.
REQ-042 LBU, addr 0x0000_0005, RAM data 0x0000_F200 -> resp_rdata_out=0x0000_00F2.
REQ-043 LW, addr 0x0000_0002 -> immediate error response, ram_valid_out never asserted.
REQ-044 ram_ready_in held low for 5 cycles during SW -> request outputs stable throughout, single handshake, single response.
REQ-045 With MAU_TIMEOUT_EN, load with no ram_rdata_valid_in -> err response after 16 WAIT_R cycles; rst asserted in WAIT_R -> IDLE the next cycle, no response.

Source files
------------

// File: rtl/mau_pkg.sv
// mau_pkg: FSM encoding, access-size codes, lane masks and request record for mem_access_unit.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: none.
package mau_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_RESP   = 2'd3
    } mau_state_t;

    // Access size codes as carried on req_size_in; 2'b11 is illegal.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // RAM byte-lane masks (bit i enables byte lane i of the 32-bit word).
    localparam logic [3:0] MASK_NONE    = 4'b0000;
    localparam logic [3:0] MASK_BYTE0   = 4'b0001;
    localparam logic [3:0] MASK_HALF_LO = 4'b0011;
    localparam logic [3:0] MASK_HALF_HI = 4'b1100;
    localparam logic [3:0] MASK_WORD    = 4'b1111;

    // Request fields captured when the unit accepts an access.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [1:0]  size;
        logic        uns;
    } mau_req_t;

    // True for the illegal size code or an access not aligned to its size.
    function automatic logic mau_bad_access(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// mau_lane_align: store byte-lane mask and load lane extraction with sign/zero extension.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs continuously.
module mau_lane_align
    import mau_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        we,
    input  logic        uns,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_en,
    output logic [31:0] ldata
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Store lane mask from size and low address bits; loads never enable lanes.
    always_comb begin
        byte_en = MASK_NONE;
        if (we) begin
            case (size)
                SZ_BYTE: byte_en = MASK_BYTE0 << addr_lo;
                SZ_HALF: byte_en = addr_lo[1] ? MASK_HALF_HI : MASK_HALF_LO;
                SZ_WORD: byte_en = MASK_WORD;
                default: byte_en = MASK_NONE;
            endcase
        end
    end

    // Select the addressed lane of the returned word, move it to bit 0 and extend.
    always_comb begin
        byte_lane = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        ldata     = rdata;
        case (size)
            SZ_BYTE: ldata = {{24{byte_lane[7] & ~uns}}, byte_lane};
            SZ_HALF: ldata = {{16{half_lane[15] & ~uns}}, half_lane};
            default: ldata = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store engine between a core and a word RAM (MAU_TIMEOUT_EN adds a read watchdog).
// Latency: acceptance to resp_valid_out is 1 cycle for errors, 2+ for stores, 3+ for loads.
// Backpressure: accepts only in IDLE; holds RAM request stable until ram_ready_in; response is never stalled.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic [31:0] req_addr_in,
    input  logic [31:0] req_wdata_in,
    input  logic        req_we_in,
    input  logic [1:0]  req_size_in,
    input  logic        req_unsigned_in,
    output logic        resp_valid_out,
    output logic [31:0] resp_rdata_out,
    output logic        resp_err_out,
    output logic        ram_valid_out,
    input  logic        ram_ready_in,
    output logic [31:0] ram_addr_out,
    output logic [31:0] ram_write_data_out,
    output logic        ram_read_en_out,
    output logic        ram_write_en_out,
    output logic [3:0]  ram_write_byte_en_out,
    input  logic        ram_rdata_valid_in,
    input  logic [31:0] ram_read_data_in
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
        $error("mem_access_unit: TIMEOUT_CYCLES must lie in 2..255");
    end

    mau_state_t  state_q;
    mau_state_t  state_d;
    mau_req_t    req_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        accept;
    logic        bad_req;
    logic        timeout;
    logic [3:0]  lane_be;
    logic [31:0] lane_ldata;

    assign accept  = (state_q == ST_IDLE) && req_valid_in;
    assign bad_req = mau_bad_access(req_size_in, req_addr_in[1:0]);

`ifdef MAU_TIMEOUT_EN
    logic [7:0] wd_cnt_q;

    // Watchdog: held at zero while the RAM request is pending, counts each WAIT_R cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q <= '0;
        end else if (state_q == ST_REQ) begin
            wd_cnt_q <= '0;
        end else if (state_q == ST_WAIT_R) begin
            wd_cnt_q <= wd_cnt_q + 8'd1;
        end
    end

    // Fires on the last permitted WAIT_R cycle when the RAM has still not answered.
    assign timeout = (state_q == ST_WAIT_R) && !ram_rdata_valid_in &&
                     (wd_cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured request, read data and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                req_q <= '{addr:  req_addr_in,
                           wdata: req_wdata_in,
                           we:    req_we_in,
                           size:  req_size_in,
                           uns:   req_unsigned_in};
                rdata_q <= '0;
                err_q   <= bad_req;
            end
            if (state_q == ST_WAIT_R) begin
                if (ram_rdata_valid_in) begin
                    rdata_q <= ram_read_data_in;
                end else if (timeout) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    mau_lane_align u_lane_align (
        .size    (req_q.size),
        .addr_lo (req_q.addr[1:0]),
        .we      (req_q.we),
        .uns     (req_q.uns),
        .rdata   (rdata_q),
        .byte_en (lane_be),
        .ldata   (lane_ldata)
    );

    // Next-state and output decode.
    always_comb begin
        state_d               = state_q;
        req_ready_out         = 1'b0;
        ram_valid_out         = 1'b0;
        ram_read_en_out       = 1'b0;
        ram_write_en_out      = 1'b0;
        ram_write_byte_en_out = MASK_NONE;
        ram_addr_out          = {2'b00, req_q.addr[31:2]};
        ram_write_data_out    = req_q.wdata;
        resp_valid_out        = 1'b0;
        resp_err_out          = 1'b0;
        resp_rdata_out        = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready_out = 1'b1;
                if (req_valid_in) begin
                    state_d = bad_req ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                ram_valid_out         = 1'b1;
                ram_read_en_out       = ~req_q.we;
                ram_write_en_out      = req_q.we;
                ram_write_byte_en_out = lane_be;
                if (ram_ready_in) begin
                    state_d = req_q.we ? ST_RESP : ST_WAIT_R;
                end
            end
            ST_WAIT_R: begin
                if (ram_rdata_valid_in || timeout) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid_out = 1'b1;
                resp_err_out   = err_q;
                if (!err_q && !req_q.we) begin
                    resp_rdata_out = lane_ldata;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
module tb_mem_access_unit;

    localparam int TO     = 16;
    localparam int BUDGET = 200;

    logic        clk;
    logic        rst;
    logic        req_valid_in;
    logic        req_ready_out;
    logic [31:0] req_addr_in;
    logic [31:0] req_wdata_in;
    logic        req_we_in;
    logic [1:0]  req_size_in;
    logic        req_unsigned_in;
    logic        resp_valid_out;
    logic [31:0] resp_rdata_out;
    logic        resp_err_out;
    logic        ram_valid_out;
    logic        ram_ready_in;
    logic [31:0] ram_addr_out;
    logic [31:0] ram_write_data_out;
    logic        ram_read_en_out;
    logic        ram_write_en_out;
    logic [3:0]  ram_write_byte_en_out;
    logic        ram_rdata_valid_in;
    logic [31:0] ram_read_data_in;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .req_valid_in          (req_valid_in),
        .req_ready_out         (req_ready_out),
        .req_addr_in           (req_addr_in),
        .req_wdata_in          (req_wdata_in),
        .req_we_in             (req_we_in),
        .req_size_in           (req_size_in),
        .req_unsigned_in       (req_unsigned_in),
        .resp_valid_out        (resp_valid_out),
        .resp_rdata_out        (resp_rdata_out),
        .resp_err_out          (resp_err_out),
        .ram_valid_out         (ram_valid_out),
        .ram_ready_in          (ram_ready_in),
        .ram_addr_out          (ram_addr_out),
        .ram_write_data_out    (ram_write_data_out),
        .ram_read_en_out       (ram_read_en_out),
        .ram_write_en_out      (ram_write_en_out),
        .ram_write_byte_en_out (ram_write_byte_en_out),
        .ram_rdata_valid_in    (ram_rdata_valid_in),
        .ram_read_data_in      (ram_read_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        uns;
        int          stall;     // cycles ram_ready_in stays low in REQ
        int          rdelay;    // WAIT_R cycles before read data; <0 = never
        logic [31:0] rdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [3:0]  exp_mask;
        int          exp_vcyc;  // cycles with ram_valid_out high
    } vec_t;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic uns, input int stall,
                                input int rdelay, input logic [31:0] rdata,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input int exp_lat, input logic [3:0] exp_mask, input int exp_vcyc);
        vec_t v;
        v.we = we; v.size = size; v.addr = addr; v.wdata = wdata; v.uns = uns;
        v.stall = stall; v.rdelay = rdelay; v.rdata = rdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        v.exp_mask = exp_mask; v.exp_vcyc = exp_vcyc;
        return v;
    endfunction

    // Reference model: expected response from the access rules using plain arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int          nbytes;
        int          off;
        logic [63:0] lanemask;
        logic [63:0] val;
        r        = v;
        nbytes   = 1 << v.size;
        off      = int'(v.addr[1:0]);
        r.exp_err   = (v.size == 2'd3) || ((v.addr % nbytes) != 0);
        r.exp_mask  = (r.exp_err || !v.we) ? 4'd0 : 4'(((1 << nbytes) - 1) << off);
        r.exp_vcyc  = r.exp_err ? 0 : v.stall + 1;
        r.exp_rdata = '0;
        if (r.exp_err) begin
            r.exp_lat = 1;
        end else if (v.we) begin
            r.exp_lat = 2 + v.stall;
        end else if (v.rdelay < 0) begin
            r.exp_lat = 2 + v.stall + TO;
            r.exp_err = 1'b1;
        end else begin
            r.exp_lat = 3 + v.stall + v.rdelay;
            lanemask  = (64'd1 << (8 * nbytes)) - 64'd1;
            val       = (64'(v.rdata) >> (8 * off)) & lanemask;
            if (!v.uns && val[8 * nbytes - 1]) val = val | ~lanemask;
            r.exp_rdata = val[31:0];
        end
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1; req_valid_in = 1'b0; ram_ready_in = 1'b0; ram_rdata_valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Run one access with garbage on all idle inputs and check the outcome against v.
    task automatic run_txn(input string tag, input vec_t v);
        int          lat, vcyc, hs, stall_seen, wcyc;
        bit          done, after_hs;
        logic [31:0] rd;
        logic        er;
        logic [69:0] exp_ram;
        exp_ram = {2'b00, v.addr[31:2], v.wdata, v.exp_mask, ~v.we, v.we};
        check({tag, ".ready"}, req_ready_out, 1);
        req_valid_in = 1'b1; req_we_in = v.we; req_size_in = v.size; req_addr_in = v.addr;
        req_wdata_in = v.wdata; req_unsigned_in = v.uns;
        ram_ready_in = 1'b0; ram_rdata_valid_in = 1'b0;
        @(posedge clk); #1;
        lat = 1; vcyc = 0; hs = 0; stall_seen = 0; wcyc = 0; done = 0; after_hs = 0; rd = '0; er = 1'b0;
        while (!done && lat <= BUDGET) begin
            req_valid_in = 1'($urandom_range(0, 1));
            req_addr_in = $urandom; req_wdata_in = $urandom; req_we_in = 1'($urandom_range(0, 1));
            req_size_in = 2'($urandom_range(0, 3)); req_unsigned_in = 1'($urandom_range(0, 1));
            ram_read_data_in = $urandom;
            ram_rdata_valid_in = 1'($urandom_range(0, 1));
            ram_ready_in = 1'($urandom_range(0, 1));
            if (resp_valid_out) begin
                done = 1; rd = resp_rdata_out; er = resp_err_out;
                req_valid_in = 1'b0;
            end else if (ram_valid_out) begin
                vcyc++;
                check({tag, ".ram_req"},
                      {ram_addr_out, ram_write_data_out, ram_write_byte_en_out, ram_read_en_out, ram_write_en_out},
                      exp_ram);
                ram_ready_in = (stall_seen >= v.stall);
                if (ram_ready_in) begin
                    hs++;
                    after_hs = 1;
                end
                stall_seen++;
            end else if (after_hs && !v.we) begin
                ram_rdata_valid_in = (v.rdelay >= 0) && (wcyc == v.rdelay);
                if (ram_rdata_valid_in) ram_read_data_in = v.rdata;
                wcyc++;
            end
            if (!done) begin
                @(posedge clk); #1;
                lat++;
            end
        end
        check({tag, ".lat"}, lat, v.exp_lat);
        check({tag, ".rdata"}, rd, v.exp_rdata);
        check({tag, ".err"}, er, v.exp_err);
        check({tag, ".valid_cycles"}, vcyc, v.exp_vcyc);
        check({tag, ".handshakes"}, hs, (v.exp_vcyc > 0) ? 1 : 0);
        if (done) begin
            @(posedge clk); #1;
            check({tag, ".pulse"}, {resp_valid_out, req_ready_out}, 2'b01);
        end else begin
            do_reset();
        end
        ram_ready_in = 1'b0; ram_rdata_valid_in = 1'b0; req_valid_in = 1'b0;
    endtask

    initial begin
        vec_t tbl[14];
        vec_t rv;
        int   resp_seen;

        rst = 1'b1; req_valid_in = 1'b0; req_addr_in = '0; req_wdata_in = '0; req_we_in = 1'b0;
        req_size_in = '0; req_unsigned_in = 1'b0; ram_ready_in = 1'b0;
        ram_rdata_valid_in = 1'b0; ram_read_data_in = '0;
        do_reset();

        check("reset_ctl", {req_ready_out, ram_valid_out, ram_read_en_out, ram_write_en_out,
                            ram_write_byte_en_out, resp_valid_out, resp_err_out}, 10'b10_0000_0000);
        check("reset_dat", {ram_addr_out, ram_write_data_out, resp_rdata_out}, 96'd0);

        //           we    size   addr           wdata          uns  st rd  rdata          exp_rdata      err lat mask     vcyc
        tbl[0]  = mk(1'b1, 2'd0, 32'h0000_0013, 32'h0000_00AB, 1'b0, 0, 0, 32'h0,         32'h0,         0,  2, 4'b1000, 1);
        tbl[1]  = mk(1'b0, 2'd1, 32'h0000_0006, 32'h0,         1'b0, 0, 0, 32'h8001_1234, 32'hFFFF_8001, 0,  3, 4'b0000, 1);
        tbl[2]  = mk(1'b0, 2'd0, 32'h0000_0005, 32'h0,         1'b1, 0, 0, 32'h0000_F200, 32'h0000_00F2, 0,  3, 4'b0000, 1);
        tbl[3]  = mk(1'b0, 2'd2, 32'h0000_0002, 32'h0,         1'b0, 0, 0, 32'h0,         32'h0,         1,  1, 4'b0000, 0);
        tbl[4]  = mk(1'b1, 2'd2, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 5, 0, 32'h0,         32'h0,         0,  7, 4'b1111, 6);
        tbl[5]  = mk(1'b0, 2'd0, 32'h0000_0003, 32'h0,         1'b0, 0, 0, 32'h80FF_FFFF, 32'hFFFF_FF80, 0,  3, 4'b0000, 1);
        tbl[6]  = mk(1'b0, 2'd1, 32'h0000_0002, 32'h0,         1'b1, 1, 2, 32'h9ABC_0000, 32'h0000_9ABC, 0,  6, 4'b0000, 2);
        tbl[7]  = mk(1'b0, 2'd2, 32'h0000_0008, 32'h0,         1'b0, 0, 0, 32'h1234_5678, 32'h1234_5678, 0,  3, 4'b0000, 1);
        tbl[8]  = mk(1'b1, 2'd1, 32'h0000_0002, 32'h0000_5A5A, 1'b0, 0, 0, 32'h0,         32'h0,         0,  2, 4'b1100, 1);
        tbl[9]  = mk(1'b0, 2'd1, 32'h0000_0001, 32'h0,         1'b0, 0, 0, 32'h0,         32'h0,         1,  1, 4'b0000, 0);
        tbl[10] = mk(1'b1, 2'd3, 32'h0000_0000, 32'h1111_1111, 1'b0, 0, 0, 32'h0,         32'h0,         1,  1, 4'b0000, 0);
        tbl[11] = mk(1'b1, 2'd0, 32'h0000_0002, 32'h0000_0077, 1'b0, 0, 0, 32'h0,         32'h0,         0,  2, 4'b0100, 1);
        tbl[12] = mk(1'b0, 2'd0, 32'h0000_0001, 32'h0,         1'b0, 0, 0, 32'h0000_8000, 32'hFFFF_FF80, 0,  3, 4'b0000, 1);
`ifdef MAU_TIMEOUT_EN
        tbl[13] = mk(1'b0, 2'd2, 32'h0000_0040, 32'h0,         1'b0, 0, -1, 32'h0,        32'h0,         1, 18, 4'b0000, 1);
`else
        tbl[13] = mk(1'b0, 2'd2, 32'h0000_0040, 32'h0,         1'b0, 0, 40, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 43, 4'b0000, 1);
`endif
        for (int i = 0; i < 14; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i]);
        end

        // Reset while waiting for read data: back to IDLE, late data ignored, no response.
        req_valid_in = 1'b1; req_we_in = 1'b0; req_size_in = 2'd2; req_addr_in = 32'h0000_0020;
        req_wdata_in = 32'h0BAD_0BAD; req_unsigned_in = 1'b0;
        @(posedge clk); #1;
        req_valid_in = 1'b0; ram_ready_in = 1'b1;
        @(posedge clk); #1;
        ram_ready_in = 1'b0;
        check("rst_wait.in_wait", {ram_valid_out, req_ready_out, resp_valid_out}, 3'b000);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ram_rdata_valid_in = 1'b1; ram_read_data_in = 32'h1234_5678;
        check("rst_wait.idle", {req_ready_out, resp_valid_out, ram_valid_out}, 3'b100);
        check("rst_wait.cleared", {ram_addr_out, ram_write_data_out}, 64'd0);
        resp_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (resp_valid_out || !req_ready_out) resp_seen++;
        end
        check("rst_wait.no_resp", resp_seen, 0);
        ram_rdata_valid_in = 1'b0;

        // Random accesses against the reference model.
        for (int n = 0; n < 120; n++) begin
            rv.we = 1'($urandom_range(0, 1));
            rv.size = 2'($urandom_range(0, 3));
            rv.addr = $urandom;
            if ($urandom_range(0, 1) == 1) rv.addr[1:0] = 2'b00;
            rv.wdata = $urandom;
            rv.uns = 1'($urandom_range(0, 1));
            rv.stall = $urandom_range(0, 3);
            rv.rdelay = $urandom_range(0, 4);
            rv.rdata = $urandom;
            rv = model(rv);
            run_txn($sformatf("rnd%0d", n), rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
